// File: rtl/vram_byte_sequencer.sv
// Steps through the bytes of a VRAM word on CAS strobes and presents them to the gate array,
// either directly or through a de-masked delay line selected in fetch units.
module vram_byte_sequencer #(
  parameter int BYTES   = 2,
  parameter int DELAY_W = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ce,
  input  logic                     cpu_n,
  input  logic                     ras_n,
  input  logic                     cas_n,
  input  logic                     de,
  input  logic                     shift_en,
  input  logic [DELAY_W-1:0]       delay,
  input  logic [8*BYTES-1:0]       vram_din,
  output logic [7:0]               vram_d,
  output logic [$clog2(BYTES)-1:0] byte_idx,
  output logic                     byte_valid
);

  localparam int IDX_W = $clog2(BYTES);
  localparam int DEPTH = (2 ** DELAY_W) - 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(BYTES - 1);

  logic       cas_n_old;
  logic       armed;
  logic [7:0] dline [DEPTH];

  logic       fetch;
  logic       step;
  logic       use_dly;
  logic [7:0] sel_byte;
  logic [7:0] push_byte;
  logic [7:0] dly_byte;

  always_comb begin
    // armed keeps a CAS already low at reset release from counting as a falling edge
    fetch     = armed && cpu_n && !ras_n && !cas_n && cas_n_old;
    step      = cpu_n && !ras_n && cas_n && !cas_n_old;
    use_dly   = shift_en && (delay != '0);

    sel_byte = '0;
    for (int unsigned k = 0; k < BYTES; k++) begin
      if (byte_idx == IDX_W'(k)) sel_byte = vram_din[8*k +: 8];
    end
    push_byte = de ? sel_byte : '0;

    dly_byte = '0;
    for (int unsigned s = 0; s < DEPTH; s++) begin
      if (delay == DELAY_W'(s + 1)) dly_byte = dline[s];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cas_n_old  <= 1'b1;
      armed      <= 1'b0;
      vram_d     <= '0;
      byte_idx   <= '0;
      byte_valid <= 1'b0;
      for (int unsigned s = 0; s < DEPTH; s++) dline[s] <= '0;
    end else if (ce) begin
      cas_n_old  <= cas_n;
      armed      <= 1'b1;
      byte_valid <= fetch;

      if (!cpu_n)
        byte_idx <= '0;
      else if (step && byte_idx != IDX_MAX)
        byte_idx <= byte_idx + 1'b1;

      if (fetch) begin
        vram_d   <= use_dly ? dly_byte : sel_byte;
        dline[0] <= push_byte;
        for (int unsigned s = 1; s < DEPTH; s++) dline[s] <= dline[s-1];
      end
    end
  end

endmodule

// File: tb/tb_vram_byte_sequencer.sv
// Bench for vram_byte_sequencer: BYTES=2 and BYTES=4 instances on shared stimulus, checked
// every cycle against a fetch-history model plus hand-computed scenario values.
module tb_vram_byte_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce, cpu_n, ras_n, cas_n, de, shift_en;
  logic [1:0]  delay;
  logic [31:0] din4;

  logic [7:0]  d2, d4;
  logic        idx2;
  logic [1:0]  idx4;
  logic        v2, v4;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  vram_byte_sequencer #(.BYTES(2), .DELAY_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .cpu_n(cpu_n), .ras_n(ras_n), .cas_n(cas_n),
    .de(de), .shift_en(shift_en), .delay(delay), .vram_din(din4[15:0]),
    .vram_d(d2), .byte_idx(idx2), .byte_valid(v2)
  );

  vram_byte_sequencer #(.BYTES(4), .DELAY_W(2)) dut4 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .cpu_n(cpu_n), .ras_n(ras_n), .cas_n(cas_n),
    .de(de), .shift_en(shift_en), .delay(delay), .vram_din(din4),
    .vram_d(d4), .byte_idx(idx4), .byte_valid(v4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: hist[i][n] is the (de-masked) byte pushed n+1 fetches ago, newest first.
  int          nb [2] = '{2, 4};
  logic [7:0]  m_d   [2];
  int unsigned m_idx [2];
  logic        m_v   [2];
  logic [7:0]  hist  [2][8];
  logic        m_prev, m_first, m_fe, m_se;
  logic [31:0] m_word;
  logic [7:0]  m_b;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_prev  = 1'b1;
      m_first = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_d[i] = 8'h00; m_idx[i] = 0; m_v[i] = 1'b0;
        for (int n = 0; n < 8; n++) hist[i][n] = 8'h00;
      end
    end else if (ce) begin
      m_fe = !m_first && cpu_n && !ras_n && !cas_n && m_prev;
      m_se = cpu_n && !ras_n && cas_n && !m_prev;
      for (int i = 0; i < 2; i++) begin
        m_word = (i == 0) ? {16'h0, din4[15:0]} : din4;
        m_b    = 8'(m_word >> (8 * m_idx[i]));
        if (m_fe) begin
          m_d[i] = (shift_en && delay != 0) ? hist[i][int'(delay) - 1] : m_b;
          for (int n = 7; n > 0; n--) hist[i][n] = hist[i][n-1];
          hist[i][0] = de ? m_b : 8'h00;
        end
        m_v[i] = m_fe;
        if (!cpu_n) m_idx[i] = 0;
        else if (m_se && m_idx[i] < nb[i] - 1) m_idx[i]++;
      end
      m_prev  = cas_n;
      m_first = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("model_d2",   32'(d2),   32'(m_d[0]));
    chk("model_idx2", 32'(idx2), m_idx[0]);
    chk("model_v2",   32'(v2),   32'(m_v[0]));
    chk("model_d4",   32'(d4),   32'(m_d[1]));
    chk("model_idx4", 32'(idx4), m_idx[1]);
    chk("model_v4",   32'(v4),   32'(m_v[1]));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_byte(input logic [7:0] val, input logic [7:0] exp, input string name);
    din4  = {24'h0, val};
    cpu_n = 1'b0; cyc();
    cpu_n = 1'b1; ras_n = 1'b0; cas_n = 1'b0; cyc();
    chk(name, 32'(d4), 32'(exp));
    chk({name, "_v"}, 32'(v4), 32'd1);
    cas_n = 1'b1; cyc();
  endtask

  logic [7:0] exp5 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};

  initial begin
    reset_n = 1'b0; ce = 1'b1; cpu_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1;
    de = 1'b1; shift_en = 1'b0; delay = 2'd0; din4 = '0;
    cyc(); cyc();
    chk("rst_d4", 32'(d4), 32'h00);
    chk("rst_idx4", 32'(idx4), 32'd0);
    chk("rst_v4", 32'(v4), 32'd0);
    reset_n = 1'b1; cyc(); cyc();

    // Scenario 1: two CAS pulses on A55A
    din4 = 32'h0000A55A; ras_n = 1'b0; cyc();
    cas_n = 1'b0; cyc();
    chk("s1_d2_a", 32'(d2), 32'h5A); chk("s1_v2_a", 32'(v2), 32'd1);
    cas_n = 1'b1; cyc();
    chk("s1_idx2_a", 32'(idx2), 32'd1); chk("s1_v2_off", 32'(v2), 32'd0);
    cas_n = 1'b0; cyc();
    chk("s1_d2_b", 32'(d2), 32'hA5); chk("s1_v2_b", 32'(v2), 32'd1);
    cas_n = 1'b1; cyc();
    chk("s1_idx2_sat", 32'(idx2), 32'd1); chk("s1_idx4", 32'(idx4), 32'd2);
    ras_n = 1'b1; cyc();

    // Scenario 2: five pulses in one RAS window saturate on the top byte
    cpu_n = 1'b0; din4 = 32'h44332211; cyc();
    cpu_n = 1'b1; ras_n = 1'b0; cyc();
    for (int p = 0; p < 5; p++) begin
      cas_n = 1'b0; cyc();
      chk($sformatf("s2_d4_%0d", p), 32'(d4), 32'(exp5[p]));
      cas_n = 1'b1; cyc();
    end
    ras_n = 1'b1;
    reset_n = 1'b0; cyc();
    reset_n = 1'b1; cyc();

    // Scenario 3: delay=1 path with de masking, then a delay change
    shift_en = 1'b1; delay = 2'd1; de = 1'b1;
    fetch_byte(8'h5A, 8'h00, "s3_a");
    fetch_byte(8'hA5, 8'h5A, "s3_b");
    fetch_byte(8'h3C, 8'hA5, "s3_c");
    de = 1'b0;
    fetch_byte(8'h77, 8'h3C, "s3_d");
    fetch_byte(8'h88, 8'h00, "s3_e");
    de = 1'b1; delay = 2'd3;
    fetch_byte(8'h99, 8'h3C, "s3_delay3");
    shift_en = 1'b0;
    fetch_byte(8'h12, 8'h12, "s3_direct");

    // Scenario 4: CPU slot clear beats a simultaneous step; fetches ignored under cpu_n=0
    delay = 2'd0; din4 = 32'h44332211; ras_n = 1'b0;
    cpu_n = 1'b0; cyc();
    cpu_n = 1'b1; cas_n = 1'b0; cyc();
    chk("s4_d4_a", 32'(d4), 32'h11);
    cas_n = 1'b1; cpu_n = 1'b0; cyc();
    chk("s4_idx4_clr", 32'(idx4), 32'd0);
    cas_n = 1'b0; cyc();
    chk("s4_v4_ign", 32'(v4), 32'd0); chk("s4_d4_hold", 32'(d4), 32'h11);
    cas_n = 1'b1; cyc();
    cpu_n = 1'b1; cas_n = 1'b0; cyc();
    chk("s4_d4_b", 32'(d4), 32'h11); chk("s4_v4_b", 32'(v4), 32'd1);
    cas_n = 1'b1; cyc();

    // Scenario 5: reset mid-fetch with the delay line loaded
    shift_en = 1'b1; delay = 2'd2; de = 1'b1;
    fetch_byte(8'hAA, 8'h11, "s5_aa");
    fetch_byte(8'hBB, 8'h11, "s5_bb");
    din4 = 32'h44332211; cpu_n = 1'b0; cyc();
    cpu_n = 1'b1; ras_n = 1'b0; cas_n = 1'b0; cyc();
    chk("s5_pre", 32'(d4), 32'hAA);
    reset_n = 1'b0; #1;
    chk("s5_rst_d4", 32'(d4), 32'h00); chk("s5_rst_idx4", 32'(idx4), 32'd0);
    chk("s5_rst_v4", 32'(v4), 32'd0);  chk("s5_rst_d2", 32'(d2), 32'h00);
    cyc(); cyc();
    reset_n = 1'b1; cyc();
    chk("s5_nofetch_a", 32'(v4), 32'd0);
    cyc();
    chk("s5_nofetch_b", 32'(v4), 32'd0);
    ras_n = 1'b1; cas_n = 1'b1; cyc();
    ras_n = 1'b0; cyc();
    cas_n = 1'b0; cyc();
    chk("s5_d4_dly2", 32'(d4), 32'h00); chk("s5_v4", 32'(v4), 32'd1);
    chk("s5_idx4", 32'(idx4), 32'd0);
    ras_n = 1'b1; cas_n = 1'b1; cyc();
    shift_en = 1'b0; ras_n = 1'b0; cyc();
    cas_n = 1'b0; cyc();
    chk("s5_byte0", 32'(d4), 32'h11);

    // Scenario 6: strobes toggling with ce=0 change nothing
    cas_n = 1'b1; cyc();
    chk("s6_idx4_pre", 32'(idx4), 32'd1);
    ce = 1'b0;
    for (int t = 0; t < 4; t++) begin
      cas_n = (t % 2 == 0) ? 1'b0 : 1'b1; cyc();
      chk($sformatf("s6_v4_%0d", t), 32'(v4), 32'd0);
      chk($sformatf("s6_d4_%0d", t), 32'(d4), 32'h11);
      chk($sformatf("s6_idx4_%0d", t), 32'(idx4), 32'd1);
    end
    ce = 1'b1; ras_n = 1'b1; cyc(); cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
